// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
// PIN_COUNT is the number of driven pins. PWM_CNT_W is the width of the period counter.
// PWM_DUTY_FULL is the duty code that holds a pin solidly high.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
    localparam int PIN_COUNT = 16;

    // Prescaler counter width: $clog2 of the prescale value, never below one bit.
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

    // Compare stage: full-scale duty is a solid high, otherwise high while below duty.
    function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                         input logic [PWM_CNT_W-1:0] duty);
        logic level;
        if (duty == PWM_DUTY_FULL) begin
            level = 1'b1;
        end else begin
            level = (cnt < duty);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Register-side and pad-side signals of the PWM output stage.
// The master modport is used by the SPI register block and the pad ring.
// The slave modport is used by the output stage itself.
interface pwm_output_stage_if;
    import pwm_pkg::*;

    logic [PWM_CNT_W-1:0] en_reg_out_7_0;
    logic [PWM_CNT_W-1:0] en_reg_out_15_8;
    logic [PWM_CNT_W-1:0] en_reg_pwm_7_0;
    logic [PWM_CNT_W-1:0] en_reg_pwm_15_8;
    logic [PWM_CNT_W-1:0] pwm_duty_cycle;
    logic [PWM_CNT_W-1:0] out_7_0;
    logic [PWM_CNT_W-1:0] out_15_8;
    logic                 period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8,
        output en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out_7_0, out_15_8, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8,
        input  en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out_7_0, out_15_8, period_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: the prescaler divides clk into ticks.
// The 8-bit period counter advances once per tick.
// wrap marks the last clk of each period.
// period_start is a registered pulse in the first clk of the next period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] cnt,
    output logic                 wrap,
    output logic                 period_start
);

    localparam int PRESCALE_W = prescale_width(PRESCALE);
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PWM_CNT_W-1:0]  CNT_LAST      = {PWM_CNT_W{1'b1}};

    logic [PRESCALE_W-1:0] prescaler_r;
    logic [PWM_CNT_W-1:0]  counter_r;
    logic                  period_start_r;
    logic                  tick_s;
    logic                  wrap_s;

    // Tick on the last prescaler count; wrap on the tick that ends the period.
    always_comb begin
        tick_s = (prescaler_r == PRESCALE_LAST);
        wrap_s = tick_s && (counter_r == CNT_LAST);
    end

    // Prescaler, period counter and period_start pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r    <= {PRESCALE_W{1'b0}};
            counter_r      <= {PWM_CNT_W{1'b0}};
            period_start_r <= 1'b0;
        end else begin
            if (tick_s) begin
                prescaler_r <= {PRESCALE_W{1'b0}};
                counter_r   <= counter_r + PWM_CNT_W'(1);
            end else begin
                prescaler_r <= prescaler_r + PRESCALE_W'(1);
                counter_r   <= counter_r;
            end
            period_start_r <= wrap_s;
        end
    end

    assign cnt          = counter_r;
    assign wrap         = wrap_s;
    assign period_start = period_start_r;

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage.
// Each of the 16 pins is driven low, driven high, or follows one shared PWM waveform.
// The mode of each pin is selected by the output-enable and PWM-enable registers.
// Macro PWM_SYNC_UPDATE_EN:
//   Defined: the duty shadow loads only at the period wrap, so each period uses a single duty value.
//   Undefined: the duty shadow follows pwm_duty_cycle every clk.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_output_stage_if.slave   bus
);

    logic [PWM_CNT_W-1:0] cnt_s;
    logic                 wrap_s;
    logic [PWM_CNT_W-1:0] duty_shadow_r;
    logic                 pwm_level_r;
    logic [PIN_COUNT-1:0] en_out_s;
    logic [PIN_COUNT-1:0] en_pwm_s;
    logic [PIN_COUNT-1:0] pin_next_s;
    logic [PIN_COUNT-1:0] pins_r;

    pwm_timebase #(
        .PRESCALE     (PRESCALE)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt          (cnt_s),
        .wrap         (wrap_s),
        .period_start (bus.period_start)
    );

    // Combine the split enable registers and select each pin's next drive value.
    always_comb begin
        en_out_s   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
        en_pwm_s   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
        pin_next_s = en_out_s & (~en_pwm_s | {PIN_COUNT{pwm_level_r}});
    end

    // Duty shadow register: loads at wrap only, or every clk when free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_r <= {PWM_CNT_W{1'b0}};
        end else begin
`ifdef PWM_SYNC_UPDATE_EN
            if (wrap_s) begin
                duty_shadow_r <= bus.pwm_duty_cycle;
            end else begin
                duty_shadow_r <= duty_shadow_r;
            end
`else
            duty_shadow_r <= bus.pwm_duty_cycle;
`endif
        end
    end

    // PWM level register, followed by the per-pin mux register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_level_r <= 1'b0;
            pins_r      <= {PIN_COUNT{1'b0}};
        end else begin
            pwm_level_r <= pwm_compare(cnt_s, duty_shadow_r);
            pins_r      <= pin_next_s;
        end
    end

    assign bus.out_7_0  = pins_r[PWM_CNT_W-1:0];
    assign bus.out_15_8 = pins_r[PIN_COUNT-1:PWM_CNT_W];

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed self-checking bench for pwm_output_stage with PRESCALE=13 (PWM period of 3328 clks).
module tb_pwm_output_stage;
    import pwm_pkg::*;

    localparam int PERIOD = 256 * 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pwm_output_stage_if bus ();

    pwm_output_stage #(
        .PRESCALE (13)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [15:0] en_out, input logic [15:0] en_pwm,
                            input logic [7:0] duty);
        bus.en_reg_out_7_0  = en_out[7:0];
        bus.en_reg_out_15_8 = en_out[15:8];
        bus.en_reg_pwm_7_0  = en_pwm[7:0];
        bus.en_reg_pwm_15_8 = en_pwm[15:8];
        bus.pwm_duty_cycle  = duty;
    endtask

    // Step until period_start is seen; n returns the clks taken.
    task automatic wait_ps(input string tag, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < 4000) begin
            step();
            n++;
            if (bus.period_start === 1'b1) found = 1'b1;
        end
        chk({tag, "_found"}, {31'd0, found}, 32'd1);
    endtask

    // Step n clks, counting samples with pin 0 high and period_start pulses.
    task automatic run(input int n, output int hi0, output int ps);
        hi0 = 0;
        ps  = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.out_7_0[0] === 1'b1) hi0++;
            if (bus.period_start === 1'b1) ps++;
        end
    endtask

    initial begin
        int n;
        int hi;
        int hi_b;
        int ps;
        int viol;
        logic [7:0] snap;

        set_regs(16'h0000, 16'h0000, 8'h00);

        // Reset state.
        #12;
        chk("reset_pins", {16'd0, bus.out_15_8, bus.out_7_0}, 32'h0);
        chk("reset_ps", {31'd0, bus.period_start}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Static-high pins with a one-clk enable latency.
        set_regs(16'hFFFF, 16'h0000, 8'h00);
        chk("static_before_edge", {16'd0, bus.out_15_8, bus.out_7_0}, 32'h0);
        step();
        chk("static_all_high", {16'd0, bus.out_15_8, bus.out_7_0}, 32'hFFFF);
        set_regs(16'h0000, 16'h0000, 8'h00);
        step();
        chk("static_all_low", {16'd0, bus.out_15_8, bus.out_7_0}, 32'h0);

        // 50% duty on pin 0: 1664 clks high out of each 3328-clk period.
        set_regs(16'h0001, 16'h0001, 8'h80);
        wait_ps("d80_sync", n);
        run(PERIOD, hi, ps);
        chk("d80_high_clks", hi, 32'd1664);
        chk("d80_ps_in_period", ps, 32'd1);
        chk("d80_ps_at_end", {31'd0, bus.period_start}, 32'd1);
        wait_ps("d80_spacing", n);
        chk("d80_ps_spacing", n, PERIOD);

        // Zero duty: pin 0 stays low across three periods.
        bus.pwm_duty_cycle = 8'h00;
        wait_ps("d00_sync", n);
        repeat (3) step();
        run(3 * PERIOD, hi, ps);
        chk("d00_high_clks", hi, 32'd0);
        chk("d00_ps_count", ps, 32'd3);

        // Full duty: pin 0 stays high with no low clk.
        bus.pwm_duty_cycle = 8'hFF;
        wait_ps("dff_sync", n);
        repeat (3) step();
        run(3 * PERIOD, hi, ps);
        chk("dff_high_clks", hi, 3 * PERIOD);
        chk("dff_ps_count", ps, 32'd3);

        // Mixed mode: pins 3:0 follow PWM, pins 7:4 are static high, pins 15:8 are low.
        set_regs(16'h00FF, 16'h000F, 8'h40);
        wait_ps("mix_sync", n);
        repeat (3) step();
        chk("mix_start_lo", {24'd0, bus.out_7_0}, 32'hFF);
        chk("mix_start_hi", {24'd0, bus.out_15_8}, 32'h00);
        hi = 0;
        viol = 0;
        snap = 8'h00;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            if (bus.out_7_0[0] === 1'b1) hi++;
            if (bus.out_15_8 !== 8'h00) viol++;
            if (bus.out_7_0[7:4] !== 4'hF) viol++;
            if (bus.out_7_0[3:0] !== 4'h0 && bus.out_7_0[3:0] !== 4'hF) viol++;
            if (i == 1000) snap = bus.out_7_0;
        end
        chk("mix_high_clks", hi, 32'd832);
        chk("mix_static_violations", viol, 32'd0);
        chk("mix_low_phase", {24'd0, snap}, 32'hF0);

        // Duty 0x40 raised to 0xC0 when the counter reaches 0x20.
        wait_ps("upd_sync", n);
        run(416, hi, ps);
        bus.pwm_duty_cycle = 8'hC0;
        run(PERIOD - 416, hi_b, n);
        ps = ps + n;
`ifdef PWM_SYNC_UPDATE_EN
        chk("upd_same_period", hi + hi_b, 32'd832);
`else
        chk("upd_same_period", hi + hi_b, 32'd2496);
`endif
        chk("upd_ps_count", ps, 32'd1);
        run(PERIOD, hi, ps);
        chk("upd_next_period", hi, 32'd2496);

        // Reset asserted during the high phase, then the first period after release.
        bus.pwm_duty_cycle = 8'h80;
        wait_ps("rst_sync", n);
        repeat (100) step();
        chk("rst_pin_high_before", {31'd0, bus.out_7_0[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_pins_immediate", {16'd0, bus.out_15_8, bus.out_7_0}, 32'h0);
        chk("rst_ps_immediate", {31'd0, bus.period_start}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ps("rst_first_ps", n);
        chk("rst_first_ps_delay", n, PERIOD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
